// File: rtl/rtc_pkg.sv
// Shared date types, BCD constants and helpers for the RTC calendar.
// Imported by rtc_days_in_month and rtc_calendar.
package rtc_pkg;

  typedef struct packed {
    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] day;
  } rtc_date_t;

  localparam logic [7:0] MON_JAN = 8'h01;
  localparam logic [7:0] MON_FEB = 8'h02;
  localparam logic [7:0] MON_MAR = 8'h03;
  localparam logic [7:0] MON_APR = 8'h04;
  localparam logic [7:0] MON_MAY = 8'h05;
  localparam logic [7:0] MON_JUN = 8'h06;
  localparam logic [7:0] MON_JUL = 8'h07;
  localparam logic [7:0] MON_AUG = 8'h08;
  localparam logic [7:0] MON_SEP = 8'h09;
  localparam logic [7:0] MON_OCT = 8'h10;
  localparam logic [7:0] MON_NOV = 8'h11;
  localparam logic [7:0] MON_DEC = 8'h12;

  localparam logic [7:0] DAYS_28 = 8'h28;
  localparam logic [7:0] DAYS_29 = 8'h29;
  localparam logic [7:0] DAYS_30 = 8'h30;
  localparam logic [7:0] DAYS_31 = 8'h31;

  localparam logic [7:0] DAY_FIRST = 8'h01;
  localparam logic [7:0] YEAR_LAST = 8'h99;

  localparam logic [23:0] RTC_DATE_RESET = 24'h000101;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[7:4];
    lo = v[3:0];
    if (lo >= 4'd9) begin
      lo = 4'd0;
      hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// Combinational BCD days-in-month lookup with leap-year rule (2000-2099).
// Ports: month_i, year_i (BCD) -> max_day_o (BCD last day of month).
module rtc_days_in_month
  import rtc_pkg::*;
(
  input  logic [7:0] month_i,
  input  logic [7:0] year_i,
  output logic [7:0] max_day_o
);

  logic [3:0] yr_hi;
  logic [3:0] yr_lo;
  logic       leap;
  logic       is_feb;
  logic       is_30;

  assign yr_hi = year_i[7:4];
  assign yr_lo = year_i[3:0];

  // Within one century, year mod 4 == 0 reduces to these digit pairs.
  assign leap =
    (!yr_hi[0] && (yr_lo == 4'd0 ||
                   yr_lo == 4'd4 ||
                   yr_lo == 4'd8)) ||
    ( yr_hi[0] && (yr_lo == 4'd2 ||
                   yr_lo == 4'd6));

  assign is_feb = (month_i == MON_FEB);
  assign is_30  = (month_i == MON_APR) ||
                  (month_i == MON_JUN) ||
                  (month_i == MON_SEP) ||
                  (month_i == MON_NOV);

  always_comb begin
    max_day_o = DAYS_31;
    unique case (1'b1)
      is_feb:  max_day_o = leap ? DAYS_29 : DAYS_28;
      is_30:   max_day_o = DAYS_30;
      default: max_day_o = DAYS_31;
    endcase
  end

endmodule

// File: rtl/rtc_calendar.sv
// BCD calendar (day/month/year 2000-2099) advanced by the day-rollover
// pulse, with a one-shot date alarm and a century rollover pulse.
// Ports: clk_i, rstn_i, update_day_i, date_update_i/date_i, date_o,
//   alarm_update_i/alarm_enable_i/alarm_date_i, alarm_date_o,
//   century_o, event_o.
// Optional: RTC_WEEKDAY_EN adds weekday_i/weekday_o and a weekday counter.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter logic [23:0] RESET_DATE = RTC_DATE_RESET
`ifdef RTC_WEEKDAY_EN
  ,
  parameter logic [2:0]  RESET_WEEKDAY = 3'd6
`endif
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        update_day_i,
  input  logic        date_update_i,
  input  logic [23:0] date_i,
  output logic [23:0] date_o,
  input  logic        alarm_update_i,
  input  logic        alarm_enable_i,
  input  logic [23:0] alarm_date_i,
  output logic [23:0] alarm_date_o,
  output logic        century_o,
  output logic        event_o
`ifdef RTC_WEEKDAY_EN
  ,
  input  logic [2:0]  weekday_i,
  output logic [2:0]  weekday_o
`endif
);

  rtc_date_t  date_q, date_d;
  rtc_date_t  alarm_q, alarm_d;
  logic       alarm_en_q, alarm_en_d;
  logic       r_match_q, r_match_d;
  logic       century_q, century_d;

  logic       tick;
  logic [7:0] max_day;
  logic       day_wrap;
  logic       mon_wrap;
  logic       yr_wrap;
  logic       s_match;

  rtc_days_in_month u_dim (
    .month_i   (date_q.month),
    .year_i    (date_q.year),
    .max_day_o (max_day)
  );

  // A software write in the same cycle swallows the tick.
  assign tick = update_day_i & ~date_update_i;

  // ">=" lets out-of-range written values recover on the next tick.
  assign day_wrap = (date_q.day >= max_day);
  assign mon_wrap = (date_q.month >= MON_DEC);
  assign yr_wrap  = (date_q.year == YEAR_LAST);

  always_comb begin
    date_d    = date_q;
    century_d = 1'b0;
    if (date_update_i) begin
      date_d = rtc_date_t'(date_i);
    end else if (tick) begin
      if (day_wrap) begin
        date_d.day = DAY_FIRST;
        if (mon_wrap) begin
          date_d.month = MON_JAN;
          date_d.year  = bcd_inc(date_q.year);
          century_d    = yr_wrap;
        end else begin
          date_d.month = bcd_inc(date_q.month);
        end
      end else begin
        date_d.day = bcd_inc(date_q.day);
      end
    end
  end

  assign s_match = (date_q == alarm_q);
  assign event_o = alarm_en_q & s_match & ~r_match_q;

  always_comb begin
    alarm_d    = alarm_q;
    alarm_en_d = alarm_en_q;
    r_match_d  = s_match;
    if (alarm_update_i) begin
      alarm_d    = rtc_date_t'(alarm_date_i);
      alarm_en_d = alarm_enable_i;
    end else if (event_o) begin
      alarm_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      date_q     <= rtc_date_t'(RESET_DATE);
      alarm_q    <= rtc_date_t'(RTC_DATE_RESET);
      alarm_en_q <= 1'b0;
      r_match_q  <= 1'b0;
      century_q  <= 1'b0;
    end else begin
      date_q     <= date_d;
      alarm_q    <= alarm_d;
      alarm_en_q <= alarm_en_d;
      r_match_q  <= r_match_d;
      century_q  <= century_d;
    end
  end

  assign date_o       = date_q;
  assign alarm_date_o = alarm_q;
  assign century_o    = century_q;

`ifdef RTC_WEEKDAY_EN
  logic [2:0] weekday_q, weekday_d;

  always_comb begin
    weekday_d = weekday_q;
    if (date_update_i) begin
      weekday_d = weekday_i;
    end else if (tick) begin
      weekday_d = (weekday_q >= 3'd6) ? 3'd0 : weekday_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      weekday_q <= RESET_WEEKDAY;
    end else begin
      weekday_q <= weekday_d;
    end
  end

  assign weekday_o = weekday_q;
`endif

endmodule
